// File: rtl/timer_pkg.sv
// Shared time-base definitions: mode/state encodings and the default counter width.
package timer_pkg;

    localparam int unsigned TIMER_CNT_W = 28;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/periodic_gate_timer.sv
// Interval timer producing a terminal tick, a square wave and a counting-gate window.
// Optional sticky tick indicator enabled by defining TIMER_STICKY_EN.
module periodic_gate_timer
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W          = TIMER_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             period_ld,
    input  logic [CNT_W-1:0] period_in,
    output logic             tick,
    output logic             square,
    output logic             gate,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             tick_flag,
    input  logic             tick_clr
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] period_shd_q, period_shd_d;
    logic             square_q, square_d;
    logic             mode_q, mode_d;
    logic             tick_c;
    logic             ld_ok;
    logic             terminal;

    // A load landing on a tick or on the start of a run takes effect immediately
    always_comb begin
        ld_ok        = period_ld && (period_in != '0);
        period_shd_d = ld_ok ? period_in : period_shd_q;
        terminal     = (count_q == (period_act_q - CNT_W'(1)));

        state_d      = state_q;
        count_d      = count_q;
        period_act_d = period_act_q;
        square_d     = square_q;
        mode_d       = mode_q;
        tick_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && ((mode == MODE_PERIODIC) || start)) begin
                    state_d      = ST_RUN;
                    count_d      = '0;
                    period_act_d = period_shd_d;
                    mode_d       = mode;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (terminal) begin
                        tick_c       = !rst;
                        count_d      = '0;
                        square_d     = ~square_q;
                        period_act_d = period_shd_d;
                        if ((mode_q == MODE_ONESHOT) && !start) begin
                            state_d = ST_IDLE;
                        end
                    end else if ((mode_q == MODE_ONESHOT) && start) begin
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            period_act_q <= RST_PERIOD;
            period_shd_q <= RST_PERIOD;
            square_q     <= 1'b0;
            mode_q       <= MODE_PERIODIC;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_act_q <= period_act_d;
            period_shd_q <= period_shd_d;
            square_q     <= square_d;
            mode_q       <= mode_d;
        end
    end

    assign tick   = tick_c;
    assign square = square_q;
    assign busy   = (state_q == ST_RUN);
    assign gate   = (state_q == ST_RUN);
    assign count  = count_q;

`ifdef TIMER_STICKY_EN
    logic tick_flag_q;

    // Set has priority over clear so a tick is never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_flag_q <= 1'b0;
        end else if (tick_c) begin
            tick_flag_q <= 1'b1;
        end else if (tick_clr) begin
            tick_flag_q <= 1'b0;
        end
    end

    assign tick_flag = tick_flag_q;
`else
    logic unused_tick_clr;

    assign unused_tick_clr = tick_clr;
    assign tick_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_periodic_gate_timer.sv
// Scoreboard bench for periodic_gate_timer: expected per-cycle snapshots are queued by the
// stimulus and compared by an independent negedge monitor.
module tb_periodic_gate_timer;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             mode;
    logic             start;
    logic             period_ld;
    logic [CNT_W-1:0] period_in;
    logic             tick;
    logic             square;
    logic             gate;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             tick_flag;
    logic             tick_clr;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int tk;
        int sq;
        int bz;
        int cnt;
        int fl;
    } exp_t;

    exp_t sb[$];

    periodic_gate_timer #(
        .CNT_W         (CNT_W),
        .DEFAULT_PERIOD(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .start    (start),
        .period_ld(period_ld),
        .period_in(period_in),
        .tick     (tick),
        .square   (square),
        .gate     (gate),
        .busy     (busy),
        .count    (count),
        .tick_flag(tick_flag),
        .tick_clr (tick_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, c, act, exp);
        end
    endtask

    // Monitor: compares every queued snapshot against the DUT in its cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cycle %0d got %0d expected %0d", cyc, cyc, e.cyc);
            end else begin
                cmp("tick",   cyc, int'(tick),   e.tk);
                cmp("square", cyc, int'(square), e.sq);
                cmp("busy",   cyc, int'(busy),   e.bz);
                cmp("gate",   cyc, int'(gate),   e.bz);
                cmp("count",  cyc, int'(count),  e.cnt);
                if (e.fl >= 0) cmp("tick_flag", cyc, int'(tick_flag), e.fl);
            end
        end
    end

    // Queue one snapshot per cycle from base; square follows the listed ticks
    task automatic push_seq(input int base, input int cnt_t[$], input int tk_t[$],
                            input int bz_t[$], input int fl_t[$], input int sq0);
        exp_t e;
        int   sq = sq0;
        for (int i = 0; i < cnt_t.size(); i++) begin
            e.cyc = base + i;
            e.tk  = tk_t[i];
            e.sq  = sq;
            e.bz  = bz_t[i];
            e.cnt = cnt_t[i];
            e.fl  = (i < fl_t.size()) ? fl_t[i] : -1;
            sb.push_back(e);
            if (tk_t[i] != 0) sq = 1 - sq;
        end
    endtask

    task automatic tic();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        start     = 1'b0;
        period_ld = 1'b0;
        period_in = '0;
        tick_clr  = 1'b0;
        tic();
        tic();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_t[$];
        int tk_t[$];
        int bz_t[$];
        int fl_t[$];
        int base;

        // 1: periodic, default period 5, reset state at k=0
        do_reset();
        en = 1'b1;
        base  = cyc;
        cnt_t = '{0, 0,1,2,3,4, 0,1,2,3,4, 0,1,2,3,4, 0};
        tk_t  = '{0, 0,0,0,0,1, 0,0,0,0,1, 0,0,0,0,1, 0};
        bz_t  = '{0, 1,1,1,1,1, 1,1,1,1,1, 1,1,1,1,1, 1};
        fl_t  = '{0};
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        repeat (17) tic();

        // 2: one-shot period 4, then a restart that is re-triggered on its terminal cycle
        do_reset();
        mode = 1'b1; en = 1'b1; period_ld = 1'b1; period_in = 8'd4;
        base  = cyc;
        cnt_t = '{0, 0,0,1,2,3, 0,0,0,0, 0,1,2,3, 0,1,2,3, 0};
        tk_t  = '{0, 0,0,0,0,1, 0,0,0,0, 0,0,0,1, 0,0,0,1, 0};
        bz_t  = '{0, 0,1,1,1,1, 0,0,0,0, 1,1,1,1, 1,1,1,1, 0};
        fl_t  = '{};
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        for (int k = 0; k < 19; k++) begin
            case (k)
                1:       begin period_ld = 1'b0; start = 1'b1; end
                9, 13:   start = 1'b1;
                default: start = 1'b0;
            endcase
            tic();
        end

        // 3: period reload mid-interval, rejected zero load, reload on a tick cycle
        do_reset();
        en = 1'b1;
        base  = cyc;
        cnt_t = '{0, 0,1,2,3,4, 0,1,2, 0,1,2, 0,1, 0,1, 0,1};
        tk_t  = '{0, 0,0,0,0,1, 0,0,1, 0,0,1, 0,1, 0,1, 0,1};
        bz_t  = '{0, 1,1,1,1,1, 1,1,1, 1,1,1, 1,1, 1,1, 1,1};
        fl_t  = '{};
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        for (int k = 0; k < 18; k++) begin
            case (k)
                2:       begin period_ld = 1'b1; period_in = 8'd3; end
                3:       begin period_ld = 1'b1; period_in = 8'd0; end
                11:      begin period_ld = 1'b1; period_in = 8'd2; end
                default: period_ld = 1'b0;
            endcase
            tic();
        end

        // 4: enable dropped for two cycles at count 2
        do_reset();
        en = 1'b1;
        base  = cyc;
        cnt_t = '{0, 0,1,2,2,2,3,4, 0,1,2,3,4, 0};
        tk_t  = '{0, 0,0,0,0,0,0,1, 0,0,0,0,1, 0};
        bz_t  = '{0, 1,1,1,1,1,1,1, 1,1,1,1,1, 1};
        fl_t  = '{};
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        for (int k = 0; k < 14; k++) begin
            en = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            tic();
        end

        // 5: one-shot retrigger, then reset mid-interval
        do_reset();
        mode = 1'b1; en = 1'b1; period_ld = 1'b1; period_in = 8'd4;
        base  = cyc;
        cnt_t = '{0, 0, 0,1,2,0,1,2,3, 0, 0,0,1};
        tk_t  = '{0, 0, 0,0,0,0,0,0,1, 0, 0,0,0};
        bz_t  = '{0, 0, 1,1,1,1,1,1,1, 0, 0,1,1};
        fl_t  = '{};
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        cnt_t = '{0};
        tk_t  = '{0};
        bz_t  = '{0};
        fl_t  = '{0};
        push_seq(base + 13, cnt_t, tk_t, bz_t, fl_t, 0);
        for (int k = 0; k < 15; k++) begin
            if (k == 1) period_ld = 1'b0;
            start = (k == 1 || k == 4 || k == 10) ? 1'b1 : 1'b0;
            rst   = (k == 12 || k == 13) ? 1'b1 : 1'b0;
            tic();
        end

        // 6: sticky indicator, clear alone and clear colliding with a tick
        do_reset();
        en = 1'b1;
        base  = cyc;
        cnt_t = '{0, 0,1,2,3,4, 0,1,2,3,4, 0,1};
        tk_t  = '{0, 0,0,0,0,1, 0,0,0,0,1, 0,0};
        bz_t  = '{0, 1,1,1,1,1, 1,1,1,1,1, 1,1};
`ifdef TIMER_STICKY_EN
        fl_t  = '{0, 0,0,0,0,0, 1,1,0,0,0, 1,1};
`else
        fl_t  = '{0, 0,0,0,0,0, 0,0,0,0,0, 0,0};
`endif
        push_seq(base, cnt_t, tk_t, bz_t, fl_t, 0);
        for (int k = 0; k < 13; k++) begin
            tick_clr = (k == 7 || k == 10) ? 1'b1 : 1'b0;
            tic();
        end

        tick_clr = 1'b0;
        repeat (3) tic();
        cmp("scoreboard_drained", cyc, sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
